// File: rtl/frame_seq_ctrl.sv
// Per-frame ingress sequencer: gates header capture, hands the header to the
// field extractor, forwards payload, and flags runt and oversize frames.
`timescale 1ns/1ps

module frame_seq_ctrl #(
    parameter int DATA_WIDTH   = 64,
    parameter int HEADER_BYTES = 18,
    parameter int MAX_BEATS    = 190
) (
    input  logic clk,
    input  logic rst,
    input  logic s_tvalid,
    input  logic s_tlast,
    output logic s_tready,
    output logic m_tvalid,
    output logic m_tlast,
    input  logic m_tready,
    output logic frame_start,
    output logic beat_accept,
    input  logic header_done,
    output logic hdr_beat_en,
    output logic hdr_valid,
    input  logic hdr_ready,
    output logic hdr_only,
    output logic err_runt,
    output logic err_oversize,
    output logic busy
);

    localparam int BPB       = DATA_WIDTH / 8;
    localparam int HDR_BEATS = (HEADER_BYTES + BPB - 1) / BPB;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    // The frame limit must leave room for the whole header.
    generate
        if (BPB < 1 || MAX_BEATS < HDR_BEATS) begin : g_cfg_check
            $error("frame_seq_ctrl: MAX_BEATS smaller than header beat count");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        TAIL_CHK,
        HDR_WAIT,
        PAYLOAD,
        DROP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic             hdr_only_q;
    logic             hdr_only_nxt;
    logic             err_runt_q;
    logic             err_runt_nxt;
    logic             err_ovs_q;
    logic             err_ovs_nxt;

    logic             s_tready_c;
    logic             m_tvalid_c;
    logic             m_tlast_c;
    logic             frame_start_c;
    logic             beat_accept_c;
    logic             hdr_valid_c;
    logic             accept;

    assign accept = s_tvalid && s_tready_c;

    always_comb begin
        state_nxt     = state;
        hdr_only_nxt  = hdr_only_q;
        err_runt_nxt  = 1'b0;
        err_ovs_nxt   = 1'b0;
        s_tready_c    = 1'b0;
        m_tvalid_c    = 1'b0;
        m_tlast_c     = 1'b0;
        frame_start_c = 1'b0;
        beat_accept_c = 1'b0;
        hdr_valid_c   = 1'b0;

        case (state)
            IDLE: begin
                // First beat is held here so the byte counter clears first.
                frame_start_c = s_tvalid;
                hdr_only_nxt  = 1'b0;
                if (s_tvalid) begin
                    state_nxt = HEADER;
                end
            end

            HEADER: begin
                s_tready_c    = !header_done;
                beat_accept_c = s_tvalid && !header_done;
                if (beat_accept_c && s_tlast) begin
                    state_nxt = TAIL_CHK;
                end else if (header_done) begin
                    state_nxt = HDR_WAIT;
                end
            end

            TAIL_CHK: begin
                if (header_done) begin
                    hdr_only_nxt = 1'b1;
                    state_nxt    = HDR_WAIT;
                end else begin
                    err_runt_nxt = 1'b1;
                    state_nxt    = IDLE;
                end
            end

            HDR_WAIT: begin
                hdr_valid_c = 1'b1;
                if (hdr_ready) begin
                    hdr_only_nxt = 1'b0;
                    state_nxt    = hdr_only_q ? IDLE : PAYLOAD;
                end
            end

            PAYLOAD: begin
                if (beat_cnt < CNT_MAX) begin
                    m_tvalid_c = s_tvalid;
                    s_tready_c = m_tready;
                    m_tlast_c  = s_tlast || (beat_cnt == CNT_LAST);
                    if (s_tvalid && m_tready) begin
                        if (s_tlast) begin
                            state_nxt = IDLE;
                        end else if (beat_cnt == CNT_LAST) begin
                            err_ovs_nxt = 1'b1;
                            state_nxt   = DROP;
                        end
                    end
                end else begin
                    // Header alone exhausted the budget: discard the rest.
                    err_ovs_nxt = 1'b1;
                    state_nxt   = DROP;
                end
            end

            DROP: begin
                s_tready_c = 1'b1;
                if (s_tvalid && s_tlast) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            hdr_only_q <= 1'b0;
            err_runt_q <= 1'b0;
            err_ovs_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            hdr_only_q <= hdr_only_nxt;
            err_runt_q <= err_runt_nxt;
            err_ovs_q  <= err_ovs_nxt;
            if (state == IDLE) begin
                beat_cnt <= '0;
            end else if (accept && state != DROP && beat_cnt != CNT_MAX) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Every output is forced low while reset is held, including frame_start.
    assign s_tready     = s_tready_c    && !rst;
    assign m_tvalid     = m_tvalid_c    && !rst;
    assign m_tlast      = m_tlast_c     && !rst;
    assign frame_start  = frame_start_c && !rst;
    assign beat_accept  = beat_accept_c && !rst;
    assign hdr_beat_en  = beat_accept_c && !rst;
    assign hdr_valid    = hdr_valid_c   && !rst;
    assign hdr_only     = hdr_only_q    && !rst;
    assign err_runt     = err_runt_q    && !rst;
    assign err_oversize = err_ovs_q     && !rst;
    assign busy         = (state != IDLE) && !rst;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Scoreboard bench for frame_seq_ctrl with a behavioural header byte counter.
`timescale 1ns/1ps

module tb_frame_seq_ctrl;

    localparam int TB_MAX = 8;
    localparam int HB     = 3;   // 18 header bytes over 8-byte beats

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_tvalid = 1'b0;
    logic s_tlast = 1'b0;
    logic m_tready = 1'b1;
    logic hdr_ready = 1'b1;
    logic header_done = 1'b0;
    logic s_tready, m_tvalid, m_tlast, frame_start, beat_accept;
    logic hdr_beat_en, hdr_valid, hdr_only, err_runt, err_oversize, busy;
    logic [10:0] outs;
    int s_data = 0;

    frame_seq_ctrl #(
        .DATA_WIDTH(64),
        .HEADER_BYTES(18),
        .MAX_BEATS(TB_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .frame_start(frame_start), .beat_accept(beat_accept),
        .header_done(header_done), .hdr_beat_en(hdr_beat_en),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_only(hdr_only),
        .err_runt(err_runt), .err_oversize(err_oversize), .busy(busy)
    );

    assign outs = {s_tready, m_tvalid, m_tlast, frame_start, beat_accept,
                   hdr_beat_en, hdr_valid, hdr_only, err_runt, err_oversize, busy};

    always #5 clk = ~clk;

    // Header byte counter: cleared by frame_start, done flag registered.
    int hdr_bytes = 0;
    always @(posedge clk) begin
        if (frame_start) begin
            hdr_bytes   <= 0;
            header_done <= 1'b0;
        end else if (beat_accept) begin
            hdr_bytes   <= hdr_bytes + 8;
            header_done <= (hdr_bytes + 8 >= 18);
        end
    end

    typedef struct {
        int id;
        bit last;
    } pay_t;

    pay_t pay_q[$];
    bit   hdr_q[$];
    int   err_q[$];   // 1 = runt, 2 = oversize

    int checks = 0;
    int errors = 0;
    int fs_cnt = 0;
    int ba_cnt = 0;
    int pay_hs = 0;
    int stall[16];
    bit tog_en = 1'b0;
    bit abort = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    initial begin
        pay_t p;
        int   e;
        bit   h;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_start) fs_cnt++;
                if (beat_accept) ba_cnt++;
                if (frame_start || beat_accept)
                    chk("fs_ba_overlap", frame_start && beat_accept, 0);
                if (beat_accept || hdr_beat_en)
                    chk("hdr_beat_en_eq", hdr_beat_en, beat_accept);
                if (m_tvalid && m_tready) begin
                    pay_hs++;
                    if (pay_q.size() == 0) begin
                        chk("unexpected_payload", s_data, 0);
                    end else begin
                        p = pay_q.pop_front();
                        chk("pay_id", s_data, p.id);
                        chk("pay_last", m_tlast, p.last);
                    end
                end
                if (hdr_valid && hdr_ready) begin
                    if (hdr_q.size() == 0) begin
                        chk("unexpected_hdr", 1, 0);
                    end else begin
                        h = hdr_q.pop_front();
                        chk("hdr_only", hdr_only, h);
                    end
                end
                if (err_runt || err_oversize) begin
                    e = err_runt ? 1 : 2;
                    if (err_q.size() == 0) begin
                        chk("unexpected_err", e, 0);
                    end else begin
                        chk("err_kind", e, err_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (tog_en) m_tready = ~m_tready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic push_expect(input int n);
        if (n < HB) begin
            err_q.push_back(1);
        end else begin
            hdr_q.push_back(n == HB);
            for (int i = HB + 1; i <= n && i <= TB_MAX; i++) begin
                pay_t p;
                p.id   = i;
                p.last = (i == n) || (i == TB_MAX);
                pay_q.push_back(p);
            end
            if (n > TB_MAX) err_q.push_back(2);
        end
    endtask

    task automatic send_frame(input int n);
        int w;
        bit stop;
        stop = 1'b0;
        for (int i = 0; i < n && i < 16; i++) begin
            s_tvalid = 1'b1;
            s_tlast  = (i == n - 1);
            s_data   = i + 1;
            stall[i] = 0;
            w = 0;
            forever begin
                @(negedge clk);
                if (abort) begin
                    stop = 1'b1;
                    break;
                end
                if (s_tready) begin
                    @(posedge clk);
                    #1;
                    break;
                end
                stall[i]++;
                w++;
                if (w > 200) begin
                    chk("beat_timeout", w, 0);
                    stop = 1'b1;
                    break;
                end
            end
            if (stop) break;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_data   = 0;
    endtask

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic run_frame(input int n);
        push_expect(n);
        fs_cnt = 0;
        ba_cnt = 0;
        send_frame(n);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("frame_start_cnt", fs_cnt, 1);
        chk("beat_accept_cnt", ba_cnt, (n < HB) ? n : HB);
        chk("pay_q_drained", pay_q.size(), 0);
        chk("hdr_q_drained", hdr_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int base;
        int drop_stall;

        // Reset: all outputs low even with s_tvalid asserted.
        rst = 1'b1;
        s_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs, 0);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", outs, 0);
        @(posedge clk);
        #1;

        // 5-beat frame: 3 header + 2 payload, one header bubble.
        run_frame(5);
        chk("first_beat_held", stall[0], 1);
        chk("header_bubble", stall[3], 2);
        chk("payload_no_stall", stall[4], 0);

        // Runt, then header-only frame.
        run_frame(2);
        run_frame(3);

        // Field extractor stalls the header handshake.
        hdr_ready = 1'b0;
        push_expect(5);
        fork
            send_frame(5);
            begin
                w = 0;
                @(negedge clk);
                while (!hdr_valid && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                chk("stall_hdr_seen", hdr_valid, 1);
                for (int k = 0; k < 10; k++) begin
                    chk("stall_hdr_valid", hdr_valid, 1);
                    chk("stall_s_tready", s_tready, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                hdr_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("payload_after_hs", m_tvalid, 1);
            end
        join
        wait_idle();
        repeat (2) @(negedge clk);
        chk("stall_pay_q_drained", pay_q.size(), 0);
        @(posedge clk);
        #1;

        // Oversize: truncated at 8 beats, tail dropped without stalls.
        run_frame(12);
        drop_stall = stall[8] + stall[9] + stall[10] + stall[11];
        chk("drop_no_stall", drop_stall, 0);

        // Backpressure, last beat coincides with the beat limit.
        tog_en = 1'b1;
        run_frame(8);
        tog_en = 1'b0;
        m_tready = 1'b1;

        // Reset in the middle of payload with toggling m_tready.
        hdr_q.push_back(1'b0);
        for (int i = 4; i <= 5; i++) begin
            pay_t p;
            p.id = i;
            p.last = 1'b0;
            pay_q.push_back(p);
        end
        base = pay_hs;
        abort = 1'b0;
        tog_en = 1'b1;
        fork
            send_frame(8);
            begin
                w = 0;
                while (pay_hs < base + 2 && w < 200) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                chk("rst_reached_payload", pay_hs >= base + 2, 1);
                rst = 1'b1;
                abort = 1'b1;
                @(negedge clk);
                chk("rst_midframe_outputs", outs, 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                chk("rst_busy", busy, 0);
                chk("rst_m_tvalid", m_tvalid, 0);
                chk("rst_no_err", {err_runt, err_oversize}, 0);
            end
        join
        tog_en = 1'b0;
        m_tready = 1'b1;
        abort = 1'b0;
        chk("rst_pay_q_drained", pay_q.size(), 0);
        chk("rst_hdr_q_drained", hdr_q.size(), 0);
        @(posedge clk);
        #1;

        // Clean frame after the aborted one.
        run_frame(5);
        chk("recover_bubble", stall[3], 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
